apu_mixer: RTL and testbench

- Downstream mixing stage between the four APU tone channels (pulse1, pulse2, triangle, noise) and the audio PWM modulator.
- On each sample strobe it snapshots the channel outputs and accumulates a per-channel weighted sum, one channel per cycle.
- It then applies a one-pole low-pass IIR filter and drives a saturated sample with a valid strobe into the PWM data input.
- Replaces the plain combinational four-way adder in the APU top level.

---
 rtl/apu_mixer_if.sv | 29 ++
 rtl/apu_mixer.sv | 141 ++++++++++++++
 tb/tb_apu_mixer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apu_mixer_if.sv
// Channel-sample and mixed-output bundle between the APU channels, the mixer and the PWM stage.
interface apu_mixer_if #(
    parameter int unsigned WIDTH_IN  = 4,
    parameter int unsigned OUT_WIDTH = 8
);
    logic                 sample_en;
    logic [WIDTH_IN-1:0]  pulse1_in;
    logic [WIDTH_IN-1:0]  pulse2_in;
    logic [WIDTH_IN-1:0]  tri_in;
    logic [WIDTH_IN-1:0]  noise_in;
    logic [11:0]          weight;
    logic [3:0]           mute;
    logic [OUT_WIDTH-1:0] mix_out;
    logic                 mix_valid;
    logic                 busy;
    logic                 overrun;

    // Channel/control side: drives samples, gains and the strobe.
    modport master (
        output sample_en, pulse1_in, pulse2_in, tri_in, noise_in, weight, mute,
        input  mix_out, mix_valid, busy, overrun
    );

    // Mixer side.
    modport slave (
        input  sample_en, pulse1_in, pulse2_in, tri_in, noise_in, weight, mute,
        output mix_out, mix_valid, busy, overrun
    );
endinterface

// File: rtl/apu_mixer.sv
// Weighted four-channel APU mixer: serial MAC, one-pole low-pass IIR, saturated output.
module apu_mixer #(
    parameter int unsigned WIDTH_IN     = 4,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter int unsigned FILTER_SHIFT = 3
) (
    input  logic         clk,
    input  logic         reset,
    apu_mixer_if.slave   bus
);

    localparam int unsigned ACC_W  = WIDTH_IN + 5;
    localparam int unsigned Y_W    = ACC_W + FILTER_SHIFT;
    localparam int unsigned PROD_W = WIDTH_IN + 3;
    localparam int unsigned CMP_W  = (Y_W > OUT_WIDTH) ? Y_W : OUT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FILT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           ch;
    logic [WIDTH_IN-1:0]  snap [4];
    logic [11:0]          weight_snap;
    logic [3:0]           mute_snap;
    logic [ACC_W-1:0]     acc;
    logic [Y_W-1:0]       y_full;

    logic [OUT_WIDTH-1:0] mix_reg;
    logic                 valid_reg;
    logic                 busy_reg;
    logic                 overrun_reg;

    logic                 busy_next;
    logic                 valid_next;
    logic                 overrun_next;

    logic [WIDTH_IN-1:0]  cur_sample;
    logic [2:0]           cur_weight;
    logic [PROD_W-1:0]    term;
    logic [Y_W-1:0]       y_full_next;
    logic [Y_W-1:0]       y_new;
    logic [OUT_WIDTH-1:0] mix_next;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fixed IDLE -> MAC x4 -> FILT -> OUT sequence per strobe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.sample_en) state_next = MAC;
            MAC:     if (ch == 2'd3) state_next = FILT;
            FILT:    state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: next values of the registered status outputs.
    always_comb begin
        busy_next    = (state_next == MAC) || (state_next == FILT);
        valid_next   = (state == FILT);
        overrun_next = overrun_reg || (bus.sample_en && (state != IDLE));
    end

    // Datapath: current channel term, IIR update and saturation.
    always_comb begin
        cur_sample = snap[ch];
        case (ch)
            2'd0:    cur_weight = weight_snap[2:0];
            2'd1:    cur_weight = weight_snap[5:3];
            2'd2:    cur_weight = weight_snap[8:6];
            default: cur_weight = weight_snap[11:9];
        endcase
        term = mute_snap[ch] ? '0 : (PROD_W'(cur_sample) * PROD_W'(cur_weight));
        // True result always fits in Y_W bits, so modular arithmetic is exact.
        y_full_next = y_full + Y_W'(acc) - (y_full >> FILTER_SHIFT);
        y_new       = y_full_next >> FILTER_SHIFT;
        mix_next    = (CMP_W'(y_new) > CMP_W'({OUT_WIDTH{1'b1}})) ? '1 : OUT_WIDTH'(y_new);
    end

    // Snapshot, accumulator, filter state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) snap[i] <= '0;
            weight_snap <= '0;
            mute_snap   <= '0;
            ch          <= '0;
            acc         <= '0;
            y_full      <= '0;
            mix_reg     <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            case (state)
                IDLE: begin
                    if (bus.sample_en) begin
                        snap[0]     <= bus.pulse1_in;
                        snap[1]     <= bus.pulse2_in;
                        snap[2]     <= bus.tri_in;
                        snap[3]     <= bus.noise_in;
                        weight_snap <= bus.weight;
                        mute_snap   <= bus.mute;
                        acc         <= '0;
                        ch          <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(term);
                    ch  <= ch + 2'd1;
                end
                FILT: begin
                    y_full  <= y_full_next;
                    mix_reg <= mix_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.mix_out   = mix_reg;
    assign bus.mix_valid = valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_apu_mixer.sv
// Directed bench: two mixers (filter bypassed and FILTER_SHIFT=3) on identical stimulus.
module tb_apu_mixer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    apu_mixer_if #(.WIDTH_IN(4), .OUT_WIDTH(8)) bus0 ();
    apu_mixer_if #(.WIDTH_IN(4), .OUT_WIDTH(8)) bus3 ();

    apu_mixer #(.WIDTH_IN(4), .OUT_WIDTH(8), .FILTER_SHIFT(0)) u_s0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    apu_mixer #(.WIDTH_IN(4), .OUT_WIDTH(8), .FILTER_SHIFT(3)) u_s3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_en(input logic en);
        bus0.sample_en = en;
        bus3.sample_en = en;
    endtask

    task automatic set_in(input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] tr,
                          input logic [3:0] nz, input logic [11:0] w, input logic [3:0] m);
        bus0.pulse1_in = p1; bus0.pulse2_in = p2; bus0.tri_in = tr; bus0.noise_in = nz;
        bus0.weight = w; bus0.mute = m;
        bus3.pulse1_in = p1; bus3.pulse2_in = p2; bus3.tri_in = tr; bus3.noise_in = nz;
        bus3.weight = w; bus3.mute = m;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_out0"},  32'(bus0.mix_out),   0);
        chk({tag, "_out3"},  32'(bus3.mix_out),   0);
        chk({tag, "_val0"},  32'(bus0.mix_valid), 0);
        chk({tag, "_val3"},  32'(bus3.mix_valid), 0);
        chk({tag, "_busy0"}, 32'(bus0.busy),      0);
        chk({tag, "_busy3"}, 32'(bus3.busy),      0);
        chk({tag, "_ovr0"},  32'(bus0.overrun),   0);
        chk({tag, "_ovr3"},  32'(bus3.overrun),   0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        set_en(1'b0);
        tick();
        tick();
        reset = 1'b0;
        chk_idle_zero(tag);
    endtask

    // Strobe in cycle 0, check busy 1..5, result in cycle 6, hold in cycle 7.
    task automatic do_mix(input string tag, input int exp0, input int exp3);
        set_en(1'b1);
        tick();
        set_en(1'b0);
        for (int k = 1; k <= 5; k++) begin
            chk({tag, "_busy0"}, 32'(bus0.busy), 1);
            chk({tag, "_busy3"}, 32'(bus3.busy), 1);
            chk({tag, "_nv0"},   32'(bus0.mix_valid), 0);
            tick();
        end
        chk({tag, "_val0"},  32'(bus0.mix_valid), 1);
        chk({tag, "_val3"},  32'(bus3.mix_valid), 1);
        chk({tag, "_idle0"}, 32'(bus0.busy), 0);
        chk({tag, "_out0"},  32'(bus0.mix_out), 32'(exp0));
        chk({tag, "_out3"},  32'(bus3.mix_out), 32'(exp3));
        tick();
        chk({tag, "_pulse0"}, 32'(bus0.mix_valid), 0);
        chk({tag, "_pulse3"}, 32'(bus3.mix_valid), 0);
        chk({tag, "_hold0"},  32'(bus0.mix_out), 32'(exp0));
        chk({tag, "_hold3"},  32'(bus3.mix_out), 32'(exp3));
    endtask

    // Directed sequence.
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_en(1'b0);
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 4'h0);
        @(negedge clk);
        do_reset("rst");

        // All inputs 15, unit weights: acc = 60.
        set_in(4'd15, 4'd15, 4'd15, 4'd15, 12'h249, 4'h0);
        do_mix("unit", 60, 7);
        chk("unit_ovr0", 32'(bus0.overrun), 0);
        chk("unit_ovr3", 32'(bus3.overrun), 0);

        // Filter step response, acc = 64 three times.
        do_reset("rst_b");
        set_in(4'd8, 4'd8, 4'd15, 4'd15, 12'h024, 4'h0);
        do_mix("step1", 64, 8);
        do_mix("step2", 64, 15);
        do_mix("step3", 64, 21);

        // Saturation, then full mute, then single-channel mute.
        do_reset("rst_c");
        set_in(4'd15, 4'd15, 4'd15, 4'd15, 12'hFFF, 4'h0);
        do_mix("sat", 255, 52);
        set_in(4'd15, 4'd15, 4'd15, 4'd15, 12'hFFF, 4'hF);
        do_mix("muteall", 0, 46);
        set_in(4'd15, 4'd15, 4'd15, 4'd15, 12'h249, 4'h1);
        do_mix("mute1", 45, 45);

        // Overrun: strobes in cycles 0, 2, 6 (ignored), 7 (accepted).
        do_reset("rst_d");
        set_in(4'd15, 4'd15, 4'd15, 4'd15, 12'h249, 4'h0);
        set_en(1'b1);
        tick();                                           // cycle 1
        set_en(1'b0);
        chk("ovr_busy1", 32'(bus0.busy), 1);
        tick();                                           // cycle 2
        set_en(1'b1);
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 4'hF);
        chk("ovr_c2_0", 32'(bus0.overrun), 0);
        chk("ovr_c2_3", 32'(bus3.overrun), 0);
        tick();                                           // cycle 3
        set_en(1'b0);
        set_in(4'd15, 4'd15, 4'd15, 4'd15, 12'h249, 4'h0);
        chk("ovr_c3_0", 32'(bus0.overrun), 1);
        chk("ovr_c3_3", 32'(bus3.overrun), 1);
        for (int k = 3; k <= 5; k++) begin
            chk("ovr_nv0", 32'(bus0.mix_valid), 0);
            tick();
        end
        chk("ovr_c6_val0", 32'(bus0.mix_valid), 1);       // cycle 6
        chk("ovr_c6_val3", 32'(bus3.mix_valid), 1);
        chk("ovr_c6_out0", 32'(bus0.mix_out), 60);
        chk("ovr_c6_out3", 32'(bus3.mix_out), 7);
        set_en(1'b1);
        tick();                                           // cycle 7
        chk("ovr_c7_val0", 32'(bus0.mix_valid), 0);
        chk("ovr_c7_busy0", 32'(bus0.busy), 0);
        tick();                                           // cycle 8
        set_en(1'b0);
        chk("ovr_c8_busy0", 32'(bus0.busy), 1);
        chk("ovr_c8_busy3", 32'(bus3.busy), 1);
        for (int k = 8; k <= 12; k++) begin
            chk("ovr_nv2_0", 32'(bus0.mix_valid), 0);
            chk("ovr_nv2_3", 32'(bus3.mix_valid), 0);
            tick();
        end
        chk("ovr_c13_val0", 32'(bus0.mix_valid), 1);      // cycle 13
        chk("ovr_c13_val3", 32'(bus3.mix_valid), 1);
        chk("ovr_c13_out0", 32'(bus0.mix_out), 60);
        chk("ovr_c13_out3", 32'(bus3.mix_out), 14);
        chk("ovr_sticky0",  32'(bus0.overrun), 1);
        tick();

        // Reset in cycle 3 of a mix aborts it and clears all state.
        set_en(1'b1);
        tick();                                           // cycle 1
        set_en(1'b0);
        tick();                                           // cycle 2
        tick();                                           // cycle 3
        reset = 1'b1;
        tick();                                           // cycle 4
        reset = 1'b0;
        chk_idle_zero("midrst");
        for (int k = 4; k <= 10; k++) begin
            chk("midrst_nv0", 32'(bus0.mix_valid), 0);
            chk("midrst_nv3", 32'(bus3.mix_valid), 0);
            tick();
        end
        do_mix("after_rst", 60, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
